// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_responder data-memory slave: memop codes,
// FSM state type and the reserved-access decode.
package dmem_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned variants only make sense for loads; 011/110/111 are never legal.
    function automatic logic is_reserved(input logic [2:0] memop, input logic wen);
        case (memop)
            MOP_B, MOP_H, MOP_W: return 1'b0;
            MOP_BU, MOP_HU:      return wen;
            default:             return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane handling for dmem_responder: store byte-enable merge into
// the old word, and load byte/half extraction with sign or zero extension.
module dmem_lane_align (
    input  logic [2:0]  memop,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic [31:0] old_word,
    output logic [31:0] wr_word,
    output logic [31:0] rd_data
);

    logic [3:0]  be;
    logic [31:0] wd_rep;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        be      = 4'b1111;
        wd_rep  = wdata;
        wr_word = old_word;
        case (memop[1:0])
            2'b00: begin
                be     = 4'b0001 << lane;
                wd_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wdata[15:0]}};
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be[i]) wr_word[8*i +: 8] = wd_rep[8*i +: 8];
        end
    end

    always_comb begin
        sel_byte = old_word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? old_word[31:16] : old_word[15:0];
        case (memop[1:0])
            2'b00:   rd_data = {{24{sel_byte[7] & ~memop[2]}}, sel_byte};
            2'b01:   rd_data = {{16{sel_half[15] & ~memop[2]}}, sel_half};
            default: rd_data = old_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: one request at a time over valid/ready, word SRAM array,
// response after LATENCY cycles. Define DMEM_MISALIGN_CHECK_EN to fault misaligned h/w.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  memop,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] memdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] mem_data,
    output logic        rsp_err
);

    localparam int         IDXW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [2:0]  op_q;
    logic        wen_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [2:0]  acc_op;
    logic        acc_wen;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [31:0] offset;
    logic [IDXW-1:0] idx;
    logic        in_range;
    logic        misalign;
    logic        acc_err;
    logic        enter_resp;
    logic        mem_we;
    logic [31:0] old_word;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic [31:0] rsp_data_d;
    logic        rsp_err_d;

    // With LATENCY==1 the access happens on the accept edge, so use the live request.
    always_comb begin
        acc_op    = (state_q == IDLE) ? memop    : op_q;
        acc_wen   = (state_q == IDLE) ? mem_wen  : wen_q;
        acc_addr  = (state_q == IDLE) ? mem_addr : addr_q;
        acc_wdata = (state_q == IDLE) ? memdata  : wdata_q;
    end

    assign offset   = acc_addr - ADDR_BASE;
    assign idx      = offset[IDXW+1:2];
    assign in_range = (acc_addr >= ADDR_BASE) && (offset < 32'(4 * DEPTH_WORDS));

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((acc_op[1:0] == 2'b01) && acc_addr[0]) ||
                      ((acc_op[1:0] == 2'b10) && (acc_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign acc_err    = !in_range || is_reserved(acc_op, acc_wen) || misalign;
    assign enter_resp = rst && (((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                                ((state_q == WAIT) && (cnt_q == 4'd0)));
    assign mem_we     = enter_resp && acc_wen && !acc_err;
    assign old_word   = mem_q[idx];

    dmem_lane_align u_lane_align (
        .memop    (acc_op),
        .lane     (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .old_word (old_word),
        .wr_word  (wr_word),
        .rd_data  (ld_data)
    );

    assign rsp_data_d = (acc_err || acc_wen) ? 32'h0 : ld_data;
    assign rsp_err_d  = acc_err;

    // NOTE: the array has no reset; it lives in its own clock-only block so it maps to SRAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx] <= wr_word;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            op_q        <= MOP_B;
            wen_q       <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        op_q    <= memop;
                        wen_q   <= mem_wen;
                        addr_q  <= mem_addr;
                        wdata_q <= memdata;
                        if (LATENCY == 1) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= rsp_data_d;
                            rsp_err_q   <= rsp_err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= rsp_data_d;
                        rsp_err_q   <= rsp_err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign mem_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory slave at the far end of the CPU load/store port (memop / memdata / mem_wen / mem_addr out of the core, mem_data back in).
- Accepts one request at a time over a valid/ready handshake and holds a word-organised SRAM array.
- Performs byte/half/word stores with lane merging, and loads with lane extraction plus sign/zero extension.
- Returns a response after a programmable latency; the core stalls on the handshake until then.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of array word 0.
- DEPTH_WORDS, 1024, array depth in 32-bit words; power of two.
- LATENCY, 1, cycles from the request-accept edge to rsp_valid rising; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- memop  in  3  access type, funct3 encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- mem_wen  in  1  1 = store, 0 = load.
- mem_addr  in  32  byte address.
- memdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- mem_data  out  32  load result, extended to 32 bits; 0 for stores.
- rsp_err  out  1  access fault for this response.

Behaviour:
- Reset (rst=0, async):
  - state returns to IDLE; any pending request is discarded.
  - rsp_valid=0, mem_data=0, rsp_err=0; req_ready=1, because it is a function of state == IDLE.
  - Array contents are not reset.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. When req_valid=1, latch memop, mem_wen, mem_addr and memdata. Go to RESP if LATENCY==1, else to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. Decrement cnt; at cnt==0 go to RESP.
  - RESP entry edge: the access is performed. The store write happens on this edge, and the load data is registered into mem_data on this edge.
  - RESP: rsp_valid=1; mem_data and rsp_err are held stable until rsp_ready=1. On the handshake edge go to IDLE and clear rsp_valid.
  - No request is accepted in the RESP handshake cycle, so back-to-back requests are spaced LATENCY+1 cycles apart at minimum.
- Address decode:
  - idx = (addr - ADDR_BASE) >> 2.
  - The access is in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS, compared on the full 32 bits with no wrap.
- Lane selection: lane = addr[1:0].
  - b/bu use byte lane lane.
  - h/hu use half lane addr[1]; addr[0] is ignored.
  - w ignores addr[1:0].
- Stores:
  - sb writes memdata[7:0] into the selected byte.
  - sh writes memdata[15:0] into the selected half.
  - sw writes the whole word.
  - Unselected bytes are preserved.
  - memop 100/101 with mem_wen=1 is reserved.
  - mem_data=0 for every store response.
- Loads:
  - b sign-extends bit 7 of the selected byte; bu zero-extends it.
  - h sign-extends bit 15 of the selected half; hu zero-extends it.
  - w returns the word.
- Fault (rsp_err=1) is raised for:
  - an out-of-range address;
  - a reserved memop (011, 110, 111, or 10x with a store).
  - On a fault the store is suppressed and mem_data=0. A fault still completes a normal handshake.
- req_valid=1 while not in IDLE is ignored; no queueing.

Optional Feature:
- Macro: DMEM_MISALIGN_CHECK_EN.
- Defined:
  - h/hu with addr[0]=1, or w with addr[1:0]!=0, is a fault: rsp_err=1, the store is suppressed, mem_data=0.
- Undefined:
  - Misaligned accesses are aligned down silently as in Behaviour.
  - Misalignment never raises rsp_err.

Decomposition:
- Shared package dmem_pkg holds:
  - memop localparams: MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU;
  - the state typedef: IDLE, WAIT, RESP;
  - the helper function is_reserved(memop, wen).
- Sub-module dmem_lane_align (purely combinational) holds the store byte-enable/merge and the load extract/extend. The top holds the FSM, counter, array and decode.

Test Plan:
- LATENCY=1: sw 0x8000_0000 ← 0xDEAD_BEEF, then lw at the same address → mem_data=0xDEADBEEF. rsp_valid rises 1 cycle after the accept edge; rsp_err=0.
- Word at 0x8000_0004 = 0x0000_0000, then sb 0x8000_0006 ← 0x80 → lw returns 0x0080_0000. lb at 0x8000_0006 → 0xFFFF_FF80; lbu → 0x0000_0080.
- sh 0x8000_0008 ← 0x0000_9234 → lh at 0x8000_000A returns 0x0000_0000; lh at 0x8000_0008 returns 0xFFFF_9234; lhu returns 0x0000_9234.
- LATENCY=4 with rsp_ready held low 3 cycles:
  - rsp_valid rises 4 cycles after accept; mem_data stays stable while rsp_ready is low.
  - req_ready stays 0 until the cycle after the handshake.
  - A second req_valid asserted during WAIT is not accepted.
- Fault cases:
  - sw to 0x7FFF_FFFC → rsp_err=1, and the array word at ADDR_BASE is unchanged.
  - memop=011 load → rsp_err=1, mem_data=0.
- Reset and misalignment:
  - Drive rst=0 mid-WAIT → rsp_valid=0 immediately, state returns to IDLE, and the pending store is not written.
  - With DMEM_MISALIGN_CHECK_EN defined, lw at 0x8000_0001 → rsp_err=1.
  - Without the macro, the same lw returns the word at 0x8000_0000.
